fpu_op_sequencer: RTL and testbench
===================================

Name: fpu_op_sequencer

Overview:
- Upstream issue/collect stage for the multi-cycle fp32 `adder` and `multiplier` cores.
- Buffers operand requests in a small FIFO and drives shared Xin/Yin plus a one-cycle start pulse to both cores. The start pulse connects to the cores' restart input.
- Waits for the selected core's done, then returns the result with a valid/ready handshake.
- Enforces a timeout, so a hung core cannot stall the pipeline.

Parameters:
FIFO_DEPTH, 4, request FIFO entries (power of two, ≥2)
TAG_W, 4, width of request tag carried to response
TIMEOUT, 63, max WAIT cycles without done before error

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request offered
req_ready  out  1  FIFO can accept (= !full)
req_op  in  1  0 = add, 1 = multiply
req_x  in  32  fp32 operand X
req_y  in  32  fp32 operand Y
req_tag  in  TAG_W  opaque tag
fpu_x  out  32  to Xin of both cores
fpu_y  out  32  to Yin of both cores
fpu_start  out  1  one-cycle restart pulse to both cores
add_z  in  32  adder Zout
add_done  in  1  adder done
mul_z  in  32  multiplier Zout
mul_done  in  1  multiplier done
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_z  out  32  fp32 result
rsp_tag  out  TAG_W  tag of the originating request
rsp_err  out  1  1 = timeout; rsp_z = 32'h7FC00000
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (reset=0, async) clears:
  - FIFO pointers and count.
  - State to IDLE.
  - Outputs: fpu_start=0, fpu_x=fpu_y=0, rsp_valid=0, rsp_z=0, rsp_tag=0, rsp_err=0.
  - Timeout counter.
  - Any in-flight operation is dropped.
  - req_ready=1 after release.
- FIFO:
  - Push on req_valid&&req_ready of {op,x,y,tag}.
  - req_ready derives from the registered count only; when full, the push is refused even if a pop occurs the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop (not full) leaves the count unchanged.
- All outputs are registered.
- FSM:
  - IDLE: if FIFO non-empty, pop the head into the op register, load fpu_x/fpu_y, then go to ISSUE. Otherwise stay.
  - ISSUE: fpu_start=1 for exactly this cycle; then go to GUARD.
  - GUARD: one cycle, done is ignored (it may still reflect the previous op); clear the timeout counter; then go to WAIT.
  - WAIT: monitor the selected done (op=0→add_done, op=1→mul_done).
    - If done=1: capture the selected z into rsp_z, set rsp_err=0, go to RESP.
    - Else if counter==TIMEOUT: rsp_z=32'h7FC00000, rsp_err=1, go to RESP.
    - Else: counter+1.
    - The counter is sized ceil(log2(TIMEOUT+1)).
  - RESP: rsp_valid=1, with rsp_z/rsp_tag/rsp_err held stable until rsp_ready=1. Then rsp_valid=0 next cycle and return to IDLE.
    - No new issue happens while in RESP, so at most one operation is outstanding.
- fpu_x/fpu_y hold stable from ISSUE through the end of WAIT.
- The unselected core's done/z are ignored.
- Latency: if done is already high in the first WAIT cycle, rsp_valid rises 4 cycles after the acceptance edge into an empty FIFO with the FSM idle. In general, latency = 4 + (WAIT cycles − 1).
- Capacity with rsp_ready=0: FIFO_DEPTH+1 requests are accepted (one held in the op register); the next request stalls.
- done asserting in the same cycle as counter==TIMEOUT: done wins and no error is raised.

Test Plan:
1. Add X=0x3F4CCCCD (0.8), Y=0xBF333333 (−0.7), tag=3, with real cores → rsp_z=0x3DCCCCD0, rsp_tag=3, rsp_err=0; fpu_start high exactly one cycle.
2. Mul X=0x40200000 (2.5), Y=0xC0200000 (−2.5), then add of the same operands back to back, rsp_ready=1 → responses in order: 0xC0C80000, then 0x00000000; second fpu_start occurs only after the first response handshake.
3. Stub add_done stuck at 0, TIMEOUT=63 → after 64 WAIT cycles rsp_valid=1, rsp_err=1, rsp_z=0x7FC00000; the next queued request then issues normally.
4. rsp_ready=0, 6 back-to-back requests → 5 accepted, req_ready=0 on the 6th. Release rsp_ready → all 5 responses arrive in order with correct tags; the 6th is accepted once the count drops.
5. Assert reset low mid-WAIT (done stubbed late) → outputs immediately at reset values, FIFO empty. After release a new request completes correctly, and the stale done pulse produces no response.
6. Hold rsp_ready=0 for 10 cycles during RESP → rsp_z/rsp_tag/rsp_err stable and fpu_start stays 0 throughout.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
// Issue/collect front end for the multi-cycle fp32 adder and multiplier cores.
// Queues operand requests, restarts both cores, and returns the selected result or a timeout NaN.
module fpu_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_op_i,
  input  logic [31:0]      req_x_i,
  input  logic [31:0]      req_y_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [31:0]      fpu_x_o,
  output logic [31:0]      fpu_y_o,
  output logic             fpu_start_o,
  input  logic [31:0]      add_z_i,
  input  logic             add_done_i,
  input  logic [31:0]      mul_z_i,
  input  logic             mul_done_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_z_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic             busy_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GUARD = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  typedef struct packed {
    logic             op;
    logic [31:0]      x;
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             mem_q [FIFO_DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             push, pop;

  logic [2:0]       state_q, state_d;
  logic             op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      fpu_x_q, fpu_x_d, fpu_y_q, fpu_y_d;
  logic             fpu_start_q, fpu_start_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_z_q, rsp_z_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;
  logic             sel_done;
  logic [31:0]      sel_z;

  // Ready comes from the registered count, so a full FIFO refuses a push even on a pop cycle.
  assign push     = req_valid_i && req_ready_q;
  assign head     = mem_q[rd_ptr_q];
  assign sel_done = op_q ? mul_done_i : add_done_i;
  assign sel_z    = op_q ? mul_z_i    : add_z_i;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{op: req_op_i, x: req_x_i, y: req_y_i, tag: req_tag_i};
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    tag_d       = tag_q;
    fpu_x_d     = fpu_x_q;
    fpu_y_d     = fpu_y_q;
    tmo_d       = tmo_q;
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          op_d    = head.op;
          tag_d   = head.tag;
          fpu_x_d = head.x;
          fpu_y_d = head.y;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_GUARD;
      S_GUARD: begin
        // The selected done may still show the previous op this cycle.
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sel_done) begin
          rsp_z_d     = sel_z;
          rsp_err_d   = 1'b0;
          rsp_tag_d   = tag_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (tmo_q == TMO_MAX) begin
          rsp_z_d     = QNAN;
          rsp_err_d   = 1'b1;
          rsp_tag_d   = tag_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    req_ready_d = (cnt_d != FULL_CNT);
    fpu_start_d = (state_d == S_ISSUE);
    busy_d      = (state_d != S_IDLE) || (cnt_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      tag_q       <= '0;
      fpu_x_q     <= '0;
      fpu_y_q     <= '0;
      fpu_start_q <= 1'b0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      state_q     <= state_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      fpu_x_q     <= fpu_x_d;
      fpu_y_q     <= fpu_y_d;
      fpu_start_q <= fpu_start_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign fpu_x_o     = fpu_x_q;
  assign fpu_y_o     = fpu_y_q;
  assign fpu_start_o = fpu_start_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_z_o     = rsp_z_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with behavioural adder/multiplier cores of programmable latency.
module tb_fpu_op_sequencer;
  localparam int TAG_W = 4;
  localparam int STUCK = 255;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             req_valid = 1'b0, req_op = 1'b0, rsp_ready = 1'b0;
  logic [31:0]      req_x = '0, req_y = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             req_ready, fpu_start, rsp_valid, rsp_err, busy;
  logic [31:0]      fpu_x, fpu_y, rsp_z;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      add_z = '0, mul_z = '0;
  logic             add_done = 1'b0, mul_done = 1'b0;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fpu_op_sequencer #(.FIFO_DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(63)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_x_i(req_x), .req_y_i(req_y), .req_tag_i(req_tag),
    .fpu_x_o(fpu_x), .fpu_y_o(fpu_y), .fpu_start_o(fpu_start),
    .add_z_i(add_z), .add_done_i(add_done), .mul_z_i(mul_z), .mul_done_i(mul_done),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_z_o(rsp_z),
    .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err), .busy_o(busy)
  );

  // Known fp32 results; other operands fall back to distinct dummy values.
  function automatic logic [31:0] add_fn(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      {32'h3F4CCCCD, 32'hBF333333}: return 32'h3DCCCCD0;
      {32'h40200000, 32'hC0200000}: return 32'h00000000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      default:                      return x + y;
    endcase
  endfunction

  function automatic logic [31:0] mul_fn(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      {32'h40200000, 32'hC0200000}: return 32'hC0C80000;
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      default:                      return x ^ y;
    endcase
  endfunction

  // Cores see the restart one edge late, so a stale done stays visible through GUARD.
  int          add_lat = 0, mul_lat = 0, add_cnt = 0, mul_cnt = 0;
  logic        start_d = 1'b0;
  logic [31:0] add_pend = '0, mul_pend = '0;

  always @(posedge clk) begin
    start_d <= fpu_start;
    if (start_d) begin
      add_pend <= add_fn(fpu_x, fpu_y);
      mul_pend <= mul_fn(fpu_x, fpu_y);
      if (add_lat == 0) begin add_done <= 1'b1; add_z <= add_fn(fpu_x, fpu_y); add_cnt <= 0; end
      else begin add_done <= 1'b0; add_cnt <= (add_lat == STUCK) ? 0 : add_lat; end
      if (mul_lat == 0) begin mul_done <= 1'b1; mul_z <= mul_fn(fpu_x, fpu_y); mul_cnt <= 0; end
      else begin mul_done <= 1'b0; mul_cnt <= (mul_lat == STUCK) ? 0 : mul_lat; end
    end else begin
      if (add_cnt == 1) begin add_done <= 1'b1; add_z <= add_pend; add_cnt <= 0; end
      else if (add_cnt > 1) add_cnt <= add_cnt - 1;
      if (mul_cnt == 1) begin mul_done <= 1'b1; mul_z <= mul_pend; mul_cnt <= 0; end
      else if (mul_cnt > 1) mul_cnt <= mul_cnt - 1;
    end
  end

  typedef struct packed { logic [31:0] z; logic [TAG_W-1:0] tag; logic err; } rsp_t;
  rsp_t rsp_q[$];
  int   hs_cyc[$], st_cyc[$];
  int   cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rsp_valid && rsp_ready) begin
      rsp_q.push_back({rsp_z, rsp_tag, rsp_err});
      hs_cyc.push_back(cyc);
    end
    if (fpu_start) st_cyc.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input logic op, input logic [31:0] x, input logic [31:0] y,
                      input logic [TAG_W-1:0] tag);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_tag = tag;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      step();
    end
    req_valid = 1'b0;
    chk("accept", ok, 1);
  endtask

  task automatic wait_rsps(input int n, input int bound);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_count", rsp_q.size(), n);
  endtask

  typedef struct {
    logic             op;
    logic [31:0]      x, y;
    logic [TAG_W-1:0] tag;
    int               lat;
    logic [31:0]      ez;
    logic             eerr;
    int               elat;
  } vec_t;

  vec_t vt[7];

  initial begin
    int lat, s0, acc;
    logic rdy5;
    logic [31:0] hz;
    vt[0] = '{1'b0, 32'h3F4CCCCD, 32'hBF333333, 4'h3, 0,     32'h3DCCCCD0, 1'b0, 4};
    vt[1] = '{1'b1, 32'h40200000, 32'hC0200000, 4'h5, 2,     32'hC0C80000, 1'b0, 6};
    vt[2] = '{1'b0, 32'h3F800000, 32'h3F800000, 4'hF, 1,     32'h40000000, 1'b0, 5};
    vt[3] = '{1'b1, 32'h40000000, 32'h40400000, 4'h0, 7,     32'h40C00000, 1'b0, 11};
    vt[4] = '{1'b0, 32'h3F4CCCCD, 32'hBF333333, 4'h9, STUCK, 32'h7FC00000, 1'b1, 67};
    vt[5] = '{1'b0, 32'h40200000, 32'hC0200000, 4'hA, 63,    32'h00000000, 1'b0, 67};
    vt[6] = '{1'b1, 32'h40200000, 32'hC0200000, 4'h6, 62,    32'hC0C80000, 1'b0, 66};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outs", {rsp_valid, fpu_start, rsp_err, busy, rsp_tag}, 0);
    chk("rst_data", {fpu_x, fpu_y}, 0);
    chk("rst_rsp_z", rsp_z, 0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Table-driven single operations
    for (int i = 0; i < 7; i++) begin
      step();
      add_lat = vt[i].op ? 0 : vt[i].lat;
      mul_lat = vt[i].op ? vt[i].lat : 0;
      s0 = st_cyc.size();
      send(vt[i].op, vt[i].x, vt[i].y, vt[i].tag);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!rsp_valid && lat < 200);
      chk($sformatf("v%0d_latency", i), lat - 1, vt[i].elat);
      chk($sformatf("v%0d_z", i), rsp_z, vt[i].ez);
      chk($sformatf("v%0d_tag", i), rsp_tag, vt[i].tag);
      chk($sformatf("v%0d_err", i), rsp_err, vt[i].eerr);
      chk($sformatf("v%0d_fpu_xy", i), {fpu_x, fpu_y}, {vt[i].x, vt[i].y});
      chk($sformatf("v%0d_starts", i), st_cyc.size() - s0, 1);
      step();
      @(negedge clk);
      chk($sformatf("v%0d_drop", i), {rsp_valid, busy}, 0);
    end

    // Back-to-back mul then add: in-order, second issue only after first handshake
    step();
    rsp_q.delete(); hs_cyc.delete(); st_cyc.delete();
    add_lat = 1; mul_lat = 2;
    send(1'b1, 32'h40200000, 32'hC0200000, 4'h1);
    send(1'b0, 32'h40200000, 32'hC0200000, 4'h2);
    wait_rsps(2, 200);
    if (rsp_q.size() >= 2 && st_cyc.size() >= 2 && hs_cyc.size() >= 2) begin
      chk("b2b_first", {rsp_q[0].z, rsp_q[0].tag, rsp_q[0].err}, {32'hC0C80000, 4'h1, 1'b0});
      chk("b2b_second", {rsp_q[1].z, rsp_q[1].tag, rsp_q[1].err}, {32'h00000000, 4'h2, 1'b0});
      chk("b2b_issue_after_hs", st_cyc[1] > hs_cyc[0], 1);
    end

    // Timeout, then the queued request issues normally
    step();
    rsp_q.delete();
    add_lat = STUCK; mul_lat = 1;
    send(1'b0, 32'h3F800000, 32'h3F800000, 4'h7);
    send(1'b1, 32'h40000000, 32'h40400000, 4'h8);
    wait_rsps(2, 300);
    if (rsp_q.size() >= 2) begin
      chk("tmo_first", {rsp_q[0].z, rsp_q[0].tag, rsp_q[0].err}, {32'h7FC00000, 4'h7, 1'b1});
      chk("tmo_next", {rsp_q[1].z, rsp_q[1].tag, rsp_q[1].err}, {32'h40C00000, 4'h8, 1'b0});
    end

    // Capacity with rsp_ready low: five accepted, sixth stalls
    step();
    rsp_q.delete();
    rsp_ready = 1'b0; add_lat = 2; mul_lat = 2;
    acc = 0; rdy5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_op = i[0]; req_x = 32'h40000000 + i; req_y = 32'h3F800000;
      req_tag = TAG_W'(i + 1);
      @(negedge clk);
      if (req_ready) acc++;
      if (i == 5) rdy5 = req_ready;
      if (i < 5) step();
    end
    chk("cap_accepted", acc, 5);
    chk("cap_sixth_ready", rdy5, 0);
    repeat (4) step();
    @(negedge clk);
    chk("cap_still_full", req_ready, 0);
    step();
    rsp_ready = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
        @(negedge clk);
        if (req_ready) ok = 1'b1;
        step();
      end
      req_valid = 1'b0;
      chk("cap_sixth_accept", ok, 1);
    end
    wait_rsps(6, 500);
    for (int i = 0; i < 6; i++) begin
      if (i < rsp_q.size())
        chk($sformatf("cap_rsp%0d", i), {rsp_q[i].z, rsp_q[i].tag, rsp_q[i].err},
            {(i[0] ? mul_fn(32'h40000000 + i, 32'h3F800000) : add_fn(32'h40000000 + i, 32'h3F800000)),
             TAG_W'(i + 1), 1'b0});
    end

    // Reset in the middle of WAIT with a second request queued
    step();
    rsp_q.delete();
    add_lat = 20; mul_lat = 20;
    send(1'b0, 32'h3F800000, 32'h3F800000, 4'h4);
    send(1'b1, 32'h40000000, 32'h40400000, 4'h5);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {rsp_valid, fpu_start, rsp_err, busy, req_ready}, 5'b00001);
    chk("mid_rst_data", {fpu_x, fpu_y}, 0);
    step();
    rst_n = 1'b1;
    repeat (30) step();
    @(negedge clk);
    chk("post_rst_no_rsp", rsp_q.size(), 0);
    chk("post_rst_idle", {rsp_valid, busy}, 0);
    step();
    add_lat = 2;
    send(1'b0, 32'h40200000, 32'hC0200000, 4'hB);
    wait_rsps(1, 100);
    if (rsp_q.size() >= 1)
      chk("post_rst_rsp", {rsp_q[0].z, rsp_q[0].tag, rsp_q[0].err}, {32'h00000000, 4'hB, 1'b0});

    // Response held under back-pressure with another request waiting
    step();
    rsp_q.delete();
    rsp_ready = 1'b0; add_lat = 1; mul_lat = 1;
    send(1'b1, 32'h40000000, 32'h40400000, 4'hC);
    send(1'b0, 32'h3F800000, 32'h3F800000, 4'hD);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 100);
    hz = rsp_z;
    chk("hold_first_z", hz, 32'h40C00000);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold_c%0d", i), {rsp_valid, fpu_start, rsp_err, rsp_tag, rsp_z},
          {1'b1, 1'b0, 1'b0, 4'hC, 32'h40C00000});
      @(negedge clk);
    end
    step();
    rsp_ready = 1'b1;
    wait_rsps(2, 100);
    if (rsp_q.size() >= 2)
      chk("hold_second", {rsp_q[1].z, rsp_q[1].tag, rsp_q[1].err}, {32'h40000000, 4'hD, 1'b0});

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
